// File: rtl/fetch_buffer_ctrl.sv
// In-order instruction buffer between fetcher and decoder: credit-limited sequential
// fetch requests, FWFT dispatch of {instr, pc} pairs, flush redirect with stale-response drop.
module fetch_buffer_ctrl #(
    parameter int              DEPTH     = 16,
    parameter int              MAX_OUTST = 4,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 'h1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic [XLEN-1:0]           flush_pc_i,
    output logic                      fetch_req_valid_o,
    input  logic                      fetch_req_ready_i,
    output logic [XLEN-1:0]           fetch_req_pc_o,
    input  logic                      fetch_rsp_valid_i,
    input  logic [XLEN-1:0]           fetch_rsp_instr_i,
    output logic                      dc_valid_o,
    input  logic                      dc_ready_i,
    output logic [XLEN-1:0]           dc_instr_o,
    output logic [XLEN-1:0]           dc_pc_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OW-1:0]   outst_q, outst_d, drop_q, drop_d;
    logic            err_q, err_d;
    logic [PW-1:0]   pcf_rd_q, pcf_rd_d, pcf_wr_q, pcf_wr_d;

    logic [XLEN-1:0] buf_instr [DEPTH];
    logic [XLEN-1:0] buf_pc    [DEPTH];
    logic [XLEN-1:0] pcf_mem   [MAX_OUTST];

    logic [SW-1:0] inflight, credit_sum;
    logic          req_fire, dc_fire, rsp_any, rsp_keep, buf_wr;

    function automatic logic [PW-1:0] pcf_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshakes on both sides are plain valid/ready: a transfer happens in a cycle
    // exactly when valid & ready are both high at the rising edge.
    // Stale (dropped) requests still hold credit until their responses return.
    assign inflight          = SW'(outst_q) + SW'(drop_q);
    assign credit_sum        = SW'(count_q) + inflight;
    assign fetch_req_valid_o = !rst && !flush_i && (credit_sum < SW'(DEPTH))
                               && (inflight < SW'(MAX_OUTST));
    assign fetch_req_pc_o    = fetch_pc_q;
    assign req_fire          = fetch_req_valid_o && fetch_req_ready_i;

    assign rsp_any  = fetch_rsp_valid_i && (inflight != '0);
    assign rsp_keep = rsp_any && (drop_q == '0);
    assign buf_wr   = rsp_keep && !flush_i;

    assign dc_valid_o = (count_q != '0);
    assign dc_instr_o = buf_instr[head_q];
    assign dc_pc_o    = buf_pc[head_q];
    assign dc_fire    = dc_valid_o && dc_ready_i && !flush_i;
    assign count_o    = count_q;
    assign err_o      = err_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        err_d      = err_q;
        pcf_rd_d   = pcf_rd_q;
        pcf_wr_d   = pcf_wr_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            pcf_wr_d   = pcf_next(pcf_wr_q);
        end
        if (rsp_any) begin
            pcf_rd_d = pcf_next(pcf_rd_q);
        end
        if (rsp_any && !rsp_keep) begin
            drop_d = drop_q - OW'(1);
        end
        outst_d = outst_q + OW'(req_fire) - OW'(rsp_keep);

        if (buf_wr) begin
            tail_d = tail_q + AW'(1);
        end
        if (dc_fire) begin
            head_d = head_q + AW'(1);
        end
        count_d = count_q + CW'(buf_wr) - CW'(dc_fire);

        if (fetch_rsp_valid_i && (inflight == '0)) begin
            err_d = 1'b1;
        end

        // Flush: every request still in flight becomes stale; the PC FIFO keeps its
        // order so stale entries drain from its head ahead of new requests.
        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = {flush_pc_i[XLEN-1:2], 2'b00};
            outst_d    = '0;
            drop_d     = OW'(inflight - SW'(rsp_any));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
            pcf_rd_q   <= '0;
            pcf_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            pcf_rd_q   <= pcf_rd_d;
            pcf_wr_q   <= pcf_wr_d;
        end
    end

    // Storage arrays carry no reset; occupancy and pointers qualify their contents.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            buf_instr[tail_q] <= fetch_rsp_instr_i;
            buf_pc[tail_q]    <= pcf_mem[pcf_rd_q];
        end
        if (req_fire) begin
            pcf_mem[pcf_wr_q] <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_buffer_ctrl.sv
// Directed bench for fetch_buffer_ctrl: a simple fetcher model answers accepted requests
// (instr = ~pc) and a scoreboard queue holds the PCs the decoder must see in order.
module tb_fetch_buffer_ctrl;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        fetch_req_valid_o;
    logic        fetch_req_ready_i;
    logic [31:0] fetch_req_pc_o;
    logic        fetch_rsp_valid_i;
    logic [31:0] fetch_rsp_instr_i;
    logic        dc_valid_o;
    logic        dc_ready_i;
    logic [31:0] dc_instr_o;
    logic [31:0] dc_pc_o;
    logic [4:0]  count_o;
    logic        err_o;

    fetch_buffer_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .flush_pc_i        (flush_pc_i),
        .fetch_req_valid_o (fetch_req_valid_o),
        .fetch_req_ready_i (fetch_req_ready_i),
        .fetch_req_pc_o    (fetch_req_pc_o),
        .fetch_rsp_valid_i (fetch_rsp_valid_i),
        .fetch_rsp_instr_i (fetch_rsp_instr_i),
        .dc_valid_o        (dc_valid_o),
        .dc_ready_i        (dc_ready_i),
        .dc_instr_o        (dc_instr_o),
        .dc_pc_o           (dc_pc_o),
        .count_o           (count_o),
        .err_o             (err_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks;
    int          errors;
    int          nreq;
    int          pops;
    logic [31:0] first_pc;
    logic [31:0] exp_req_pc;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    logic        fetch_ready;
    logic        hold;
    logic        inject;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input bit do_chk);
        rst               = 1'b1;
        flush_i           = 1'b0;
        flush_pc_i        = '0;
        fetch_req_ready_i = 1'b0;
        fetch_rsp_valid_i = 1'b0;
        fetch_rsp_instr_i = '0;
        dc_ready_i        = 1'b0;
        fetch_ready       = 1'b0;
        hold              = 1'b0;
        inject            = 1'b0;
        pend_q.delete();
        exp_q.delete();
        exp_req_pc = 32'h1000;
        nreq = 0;
        pops = 0;
        first_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        if (do_chk) begin
            check("rst_req_valid", 32'(fetch_req_valid_o), 32'd0);
            check("rst_count", 32'(count_o), 32'd0);
            check("rst_dc_valid", 32'(dc_valid_o), 32'd0);
            check("rst_err", 32'(err_o), 32'd0);
            check("rst_req_pc", fetch_req_pc_o, 32'h1000);
        end
        rst = 1'b0;
    endtask

    // One clock cycle: fetcher model drives its side, handshakes are scored, model updates.
    task automatic tick();
        logic        rsp, req_hs, dc_hs;
        logic [31:0] acc_pc;
        logic [31:0] e;
        rsp = inject || (!hold && (pend_q.size() != 0));
        fetch_rsp_valid_i = rsp;
        fetch_rsp_instr_i = inject ? 32'hDEAD_BEEF : ((pend_q.size() != 0) ? ~pend_q[0] : '0);
        fetch_req_ready_i = fetch_ready;
        #1;
        req_hs = fetch_req_valid_o && fetch_req_ready_i;
        dc_hs  = dc_valid_o && dc_ready_i;
        acc_pc = fetch_req_pc_o;
        if (req_hs) check("req_pc", fetch_req_pc_o, exp_req_pc);
        if (dc_hs && !flush_i) begin
            if (exp_q.size() == 0) begin
                check("dc_extra_pop", 32'(exp_q.size() != 0), 32'd1);
            end else begin
                e = exp_q.pop_front();
                if (pops == 0) first_pc = dc_pc_o;
                check("dc_pc", dc_pc_o, e);
                check("dc_instr", dc_instr_o, ~e);
                pops++;
            end
        end
        @(posedge clk);
        if (rsp && !inject) void'(pend_q.pop_front());
        if (req_hs) begin
            pend_q.push_back(acc_pc);
            exp_q.push_back(exp_req_pc);
            exp_req_pc = exp_req_pc + 32'd4;
            nreq++;
        end
        if (flush_i) begin
            exp_q.delete();
            exp_req_pc = {flush_pc_i[31:2], 2'b00};
        end
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Sequential flow, fetcher answers one cycle after accept
        do_reset(1'b1);
        dc_ready_i = 1'b1; fetch_ready = 1'b1;
        repeat (12) tick();
        check("seq_pops", 32'(pops), 32'd10);

        // Decoder stalled: buffer fills to DEPTH, then one pop frees exactly one credit
        do_reset(1'b0);
        fetch_ready = 1'b1;
        repeat (30) tick();
        check("full_nreq", 32'(nreq), 32'd16);
        check("full_count", 32'(count_o), 32'd16);
        check("full_req_valid", 32'(fetch_req_valid_o), 32'd0);
        dc_ready_i = 1'b1;
        tick();
        dc_ready_i = 1'b0;
        repeat (10) tick();
        check("refill_nreq", 32'(nreq), 32'd17);
        check("refill_count", 32'(count_o), 32'd16);

        // Fetcher holds responses: MAX_OUTST limit
        do_reset(1'b0);
        dc_ready_i = 1'b1; fetch_ready = 1'b1; hold = 1'b1;
        repeat (6) tick();
        check("outst_nreq", 32'(nreq), 32'd4);
        check("outst_req_valid", 32'(fetch_req_valid_o), 32'd0);
        hold = 1'b0;
        tick();
        check("outst_req_rise", 32'(fetch_req_valid_o), 32'd1);
        repeat (20) tick();

        // Flush to 0x2002 with 5 buffered and 3 in flight
        do_reset(1'b0);
        fetch_ready = 1'b1;
        repeat (6) tick();
        check("fl_pre_count", 32'(count_o), 32'd5);
        hold = 1'b1;
        repeat (2) tick();
        check("fl_pre_nreq", 32'(nreq), 32'd8);
        flush_i = 1'b1; flush_pc_i = 32'h2002;
        #1;
        check("fl_req_valid", 32'(fetch_req_valid_o), 32'd0);
        tick();
        flush_i = 1'b0;
        check("fl_count", 32'(count_o), 32'd0);
        check("fl_req_pc", fetch_req_pc_o, 32'h2000);
        check("fl_dc_valid", 32'(dc_valid_o), 32'd0);
        hold = 1'b0; dc_ready_i = 1'b1; pops = 0;
        repeat (20) tick();
        check("fl_first_pc", first_pc, 32'h2000);
        check("fl_err", 32'(err_o), 32'd0);

        // Flush coincident with response, dispatch pop and request attempt
        do_reset(1'b0);
        fetch_ready = 1'b1;
        repeat (4) tick();
        hold = 1'b1;
        tick();
        hold = 1'b0; dc_ready_i = 1'b1;
        flush_i = 1'b1; flush_pc_i = 32'h3000;
        #1;
        check("co_req_valid", 32'(fetch_req_valid_o), 32'd0);
        tick();
        flush_i = 1'b0;
        check("co_count", 32'(count_o), 32'd0);
        check("co_dc_valid", 32'(dc_valid_o), 32'd0);
        check("co_req_pc", fetch_req_pc_o, 32'h3000);
        hold = 1'b1; nreq = 0; pops = 0;
        repeat (6) tick();
        check("co_credit_nreq", 32'(nreq), 32'd3);
        hold = 1'b0;
        repeat (15) tick();
        check("co_first_pc", first_pc, 32'h3000);
        check("co_err", 32'(err_o), 32'd0);

        // Response with nothing outstanding
        do_reset(1'b0);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        tick();
        check("err_pre", 32'(err_o), 32'd0);
        check("err_pre_count", 32'(count_o), 32'd1);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("err_set", 32'(err_o), 32'd1);
        check("err_count", 32'(count_o), 32'd1);
        check("err_dc_pc", dc_pc_o, 32'h1000);
        tick();
        check("err_sticky", 32'(err_o), 32'd1);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count_o), 32'd0);
        check("arst_err", 32'(err_o), 32'd0);
        check("arst_dc_valid", 32'(dc_valid_o), 32'd0);
        check("arst_req_pc", fetch_req_pc_o, 32'h1000);

        // Pointer wrap: 40 pops with an irregular decoder ready pattern
        do_reset(1'b0);
        fetch_ready = 1'b1;
        for (int i = 0; i < 200 && pops < 40; i++) begin
            dc_ready_i = (i % 3) != 0;
            tick();
        end
        check("wrap_pops", 32'(pops), 32'd40);
        check("wrap_err", 32'(err_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
